dual_input_ram_fifo: RTL and testbench

- Single-clock FIFO storage block of depth 2^ADDR_WIDTH (default 32 × 32-bit).
- The read and write pointers are supplied externally by the surrounding FIFO controller. Each pointer is ADDR_WIDTH+1 bits: the MSB is a wrap bit, the lower bits are the RAM address.
- The block holds the RAM and a registered read port, derives full/empty/level from the pointers, and flags illegal accesses.

---
 rtl/dual_input_ram_fifo.sv | 93 +++++++++
 tb/tb_dual_input_ram_fifo.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/dual_input_ram_fifo.sv
// dual_input_ram_fifo
//   Single-clock FIFO storage: RAM plus registered read port. The FIFO
//   controller supplies the pointers. Each pointer is ADDR_WIDTH+1 bits: the
//   MSB is a wrap bit and the low bits are the RAM address. This block derives
//   full/empty/level from the pointers and flags refused accesses.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   wptr, rptr         write/read pointers {wrap, addr}
//   writeEnable, wd    write request and data
//   readEnable         read request
//   rd, rd_valid       registered read data; rd_valid marks a fresh read
//   full, empty, level combinational status derived from the pointers
//   wr_err, rd_err     one-cycle pulses for a write while full / read while empty
module dual_input_ram_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH:0]   wptr,
  input  logic [ADDR_WIDTH:0]   rptr,
  input  logic                  writeEnable,
  input  logic                  readEnable,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;

  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_err_q, wr_err_d;
  logic                  rd_err_q, rd_err_d;

  assign waddr = wptr[ADDR_WIDTH-1:0];
  assign raddr = rptr[ADDR_WIDTH-1:0];

  // Wrap bit only distinguishes full from empty when the addresses match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) && (waddr == raddr);
  assign level = wptr - rptr;

  // RAM has no reset; a write is suppressed while resetn is low.
  always_ff @(posedge clk) begin
    if (resetn && writeEnable && !full) begin
      mem_q[waddr] <= wd;
    end
  end

  // Read samples the old word, so a same-edge write to the same address
  // is seen only by a later read (read-before-write).
  always_comb begin
    rd_d       = rd_q;
    rd_valid_d = 1'b0;
    wr_err_d   = writeEnable && full;
    rd_err_d   = readEnable && empty;
    if (readEnable && !empty) begin
      rd_d       = mem_q[raddr];
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
      wr_err_q   <= wr_err_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign rd       = rd_q;
  assign rd_valid = rd_valid_q;
  assign wr_err   = wr_err_q;
  assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_dual_input_ram_fifo.sv
// Directed bench for dual_input_ram_fifo: a memory model plus a queue of
// expected read words, pushed when a read is driven and popped when rd_valid
// shows up one edge later.
module tb_dual_input_ram_fifo;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          resetn;
  logic [AW:0]   wptr, rptr;
  logic          writeEnable, readEnable;
  logic [DW-1:0] wd;
  logic [DW-1:0] rd;
  logic          rd_valid, full, empty, wr_err, rd_err;
  logic [AW:0]   level;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_rd;

  dual_input_ram_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn), .wptr(wptr), .rptr(rptr),
    .writeEnable(writeEnable), .readEnable(readEnable), .wd(wd),
    .rd(rd), .rd_valid(rd_valid), .full(full), .empty(empty),
    .level(level), .wr_err(wr_err), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, check flags combinationally, then check
  // the registered outputs just after the edge.
  task automatic cyc(input logic we, input logic re, input logic [AW:0] wp,
                     input logic [AW:0] rp, input logic [DW-1:0] d);
    logic          e_empty, e_full, e_valid, e_werr, e_rerr;
    logic [AW:0]   e_level;
    logic [DW-1:0] e_rd;
    writeEnable = we; readEnable = re; wptr = wp; rptr = rp; wd = d;
    #1;
    e_empty = (wp == rp);
    e_full  = ((wp ^ rp) == 6'b100000);
    e_level = wp - rp;
    chk("empty", {31'b0, empty}, {31'b0, e_empty});
    chk("full",  {31'b0, full},  {31'b0, e_full});
    chk("level", {26'b0, level}, {26'b0, e_level});
    e_valid = re && !e_empty;
    e_rerr  = re && e_empty;
    e_werr  = we && e_full;
    if (e_valid) exp_q.push_back(model_mem[rp[AW-1:0]]);
    if (we && !e_full) model_mem[wp[AW-1:0]] = d;
    @(posedge clk);
    #1;
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, e_valid});
    chk("wr_err",   {31'b0, wr_err},   {31'b0, e_werr});
    chk("rd_err",   {31'b0, rd_err},   {31'b0, e_rerr});
    if (e_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard: observed=empty expected=entry");
      end else begin
        e_rd = exp_q.pop_front();
        chk("rd_data", rd, e_rd);
        last_rd = e_rd;
      end
    end else begin
      chk("rd_hold", rd, last_rd);
    end
  endtask

  // Reset held two cycles with both enables active; write targets address 0
  // with a non-full pointer pair, so any leak into the RAM shows up later.
  task automatic do_reset();
    resetn = 1'b0; writeEnable = 1'b1; readEnable = 1'b1;
    wptr = 6'd0; rptr = 6'd1; wd = 32'h0000_0BAD;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd",       rd,                 32'h0);
    chk("rst_rd_valid", {31'b0, rd_valid},  32'h0);
    chk("rst_wr_err",   {31'b0, wr_err},    32'h0);
    chk("rst_rd_err",   {31'b0, rd_err},    32'h0);
    exp_q.delete();
    last_rd = '0;
    resetn = 1'b1;
    writeEnable = 1'b0; readEnable = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    do_reset();

    // Fill 0..31
    for (int k = 0; k < DEPTH; k++) cyc(1'b1, 1'b0, 6'(k), 6'd0, DW'(k));
    cyc(1'b0, 1'b0, 6'd32, 6'd0, '0);

    // Write while full is refused
    cyc(1'b1, 1'b0, 6'd32, 6'd0, 32'hDEAD);
    cyc(1'b0, 1'b0, 6'd32, 6'd0, '0);

    // Mid-stream reset must not write mem[0]
    do_reset();

    // Drain 0..31; mem[0] must still hold 0
    for (int k = 0; k < DEPTH; k++) cyc(1'b0, 1'b1, 6'd32, 6'(k), '0);
    cyc(1'b0, 1'b0, 6'd32, 6'd32, '0);

    // Read while empty is refused, rd holds
    cyc(1'b0, 1'b1, 6'd5, 6'd5, '0);
    cyc(1'b0, 1'b0, 6'd5, 6'd5, '0);

    // Same address: mem[3]=0x11, then pointers 35/3 (full, so the write of
    // 0x22 is refused) with a read that returns the old word.
    cyc(1'b1, 1'b0, 6'd3, 6'd3, 32'h11);
    cyc(1'b1, 1'b1, 6'd35, 6'd3, 32'h22);
    cyc(1'b0, 1'b1, 6'd35, 6'd3, '0);

    // Simultaneous write and read at different addresses across the wrap
    cyc(1'b0, 1'b0, 6'd40, 6'd36, '0);
    cyc(1'b1, 1'b1, 6'd40, 6'd36, 32'hCAFE);
    cyc(1'b0, 1'b1, 6'd41, 6'd40, '0);
    cyc(1'b0, 1'b1, 6'd9,  6'd8,  '0);
    cyc(1'b0, 1'b0, 6'd9,  6'd9,  '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
